// File: rtl/wasm_pkg.sv
// Shared WASM definitions: opcode constants, immediate classes, decoder states and trap codes.
// Used by the loader, the fetch/decode stage and the executor.
package wasm_pkg;

    localparam logic [7:0] OP_UNREACHABLE = 8'h00;
    localparam logic [7:0] OP_NOP         = 8'h01;
    localparam logic [7:0] OP_BLOCK       = 8'h02;
    localparam logic [7:0] OP_LOOP        = 8'h03;
    localparam logic [7:0] OP_IF          = 8'h04;
    localparam logic [7:0] OP_END         = 8'h0B;
    localparam logic [7:0] OP_BR          = 8'h0C;
    localparam logic [7:0] OP_BR_IF       = 8'h0D;
    localparam logic [7:0] OP_RETURN      = 8'h0F;
    localparam logic [7:0] OP_CALL        = 8'h10;
    localparam logic [7:0] OP_DROP        = 8'h1A;
    localparam logic [7:0] OP_SELECT      = 8'h1B;
    localparam logic [7:0] OP_LOCAL_GET   = 8'h20;
    localparam logic [7:0] OP_GLOBAL_SET  = 8'h24;
    localparam logic [7:0] OP_MEM_FIRST   = 8'h28;
    localparam logic [7:0] OP_MEM_LAST    = 8'h3E;
    localparam logic [7:0] OP_I32_CONST   = 8'h41;
    localparam logic [7:0] OP_NUM_FIRST   = 8'h45;
    localparam logic [7:0] OP_NUM_LAST    = 8'hC4;

    typedef enum logic [2:0] {
        IC_NONE,
        IC_BLOCKTYPE,
        IC_ULEB,
        IC_SLEB,
        IC_MEMARG,
        IC_BAD
    } imm_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_FETCH_IMM0,
        ST_FETCH_IMM1,
        ST_EMIT,
        ST_TRAP
    } fd_state_e;

    localparam logic [1:0] TRAP_NONE         = 2'd0;
    localparam logic [1:0] TRAP_UNKNOWN_OP   = 2'd1;
    localparam logic [1:0] TRAP_LEB_OVERLONG = 2'd2;
    localparam logic [1:0] TRAP_FETCH_END    = 2'd3;

    function automatic imm_class_e classify(input logic [7:0] op);
        imm_class_e cls;
        cls = IC_BAD;
        if (op inside {OP_UNREACHABLE, OP_NOP, OP_END, OP_RETURN, OP_DROP, OP_SELECT,
                       [OP_NUM_FIRST:OP_NUM_LAST]})
            cls = IC_NONE;
        else if (op inside {[OP_BLOCK:OP_IF]})
            cls = IC_BLOCKTYPE;
        else if (op inside {OP_BR, OP_BR_IF, OP_CALL, [OP_LOCAL_GET:OP_GLOBAL_SET]})
            cls = IC_ULEB;
        else if (op == OP_I32_CONST)
            cls = IC_SLEB;
        else if (op inside {[OP_MEM_FIRST:OP_MEM_LAST]})
            cls = IC_MEMARG;
        return cls;
    endfunction

endpackage

// File: rtl/wasm_leb_accum.sv
// LEB128 (u32/i32) accumulator: one byte per step, value/done/overflow are combinational on the
// stepped byte; state self-clears when an immediate finishes or overflows.
module wasm_leb_accum #(
    parameter int unsigned MAX_LEB_BYTES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        step_i,
    input  logic        signed_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] value_o,
    output logic        done_o,
    output logic        overflow_o
);

    localparam int unsigned CW = $clog2(MAX_LEB_BYTES + 1);

    logic [CW-1:0] cnt_q;
    logic [31:0]   acc_q;
    logic [5:0]    shamt;
    logic [5:0]    top_bit;
    logic [31:0]   part;
    logic [31:0]   ext;
    logic          sext;

    assign shamt      = 6'(cnt_q) * 6'd7;
    assign top_bit    = shamt + 6'd7;
    assign part       = {25'd0, byte_i[6:0]} << shamt;
    assign ext        = {32{1'b1}} << top_bit;
    assign done_o     = step_i & ~byte_i[7];
    assign overflow_o = step_i & byte_i[7] & (cnt_q == CW'(MAX_LEB_BYTES - 1));
    // Sign extension only applies when the final group leaves room below bit 32.
    assign sext       = done_o & signed_i & byte_i[6] & (top_bit < 6'd32);
    assign value_o    = acc_q | part | (sext ? ext : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear_i || done_o || overflow_o) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= value_o;
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/wasm_fetch_decode.sv
// WASM fetch/decode stage: byte-serial fetch from code memory, opcode classification,
// LEB128 immediate decode, valid/ready instruction output, PC redirects and sticky traps.
module wasm_fetch_decode
    import wasm_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned MAX_LEB_BYTES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rom_mapped,
    input  logic [ADDR_W-1:0] first_instruction,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    input  logic              mem_rd_ready,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [7:0]        ins_opcode,
    output logic [31:0]       ins_imm0,
    output logic [31:0]       ins_imm1,
    output logic [ADDR_W-1:0] ins_pc,
    output logic [ADDR_W-1:0] ins_next_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              trap,
    output logic [1:0]        trap_code
);

    fd_state_e         state_q;
    imm_class_e        cls_q;
    imm_class_e        op_cls;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ins_pc_q;
    logic [ADDR_W-1:0] npc_q;
    logic [7:0]        opcode_q;
    logic [31:0]       imm0_q;
    logic [31:0]       imm1_q;
    logic              rd_en_q;
    logic              valid_q;
    logic              trap_q;
    logic [1:0]        tcode_q;

    logic              active;
    logic              redir;
    logic              rd_done;
    logic              leb_step;
    logic              leb_clear;
    logic              leb_signed;
    logic [31:0]       leb_value;
    logic              leb_done;
    logic              leb_ovf;

    assign active     = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign redir      = redirect_valid & active;
    assign rd_done    = rd_en_q & mem_rd_ready;
    assign pc_inc     = pc_q + ADDR_W'(1);
    assign op_cls     = classify(mem_rd_data);
    assign leb_step   = rd_done & ~redir &
                        (((state_q == ST_FETCH_IMM0) && (cls_q != IC_BLOCKTYPE)) ||
                         (state_q == ST_FETCH_IMM1));
    assign leb_clear  = redir | (state_q == ST_FETCH_OP);
    assign leb_signed = (state_q == ST_FETCH_IMM0) && (cls_q == IC_SLEB);

    wasm_leb_accum #(.MAX_LEB_BYTES(MAX_LEB_BYTES)) u_leb (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (leb_clear),
        .step_i     (leb_step),
        .signed_i   (leb_signed),
        .byte_i     (mem_rd_data),
        .value_o    (leb_value),
        .done_o     (leb_done),
        .overflow_o (leb_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cls_q    <= IC_NONE;
            pc_q     <= '0;
            ins_pc_q <= '0;
            npc_q    <= '0;
            opcode_q <= '0;
            imm0_q   <= '0;
            imm1_q   <= '0;
            rd_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            trap_q   <= 1'b0;
            tcode_q  <= TRAP_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rom_mapped) begin
                        pc_q    <= first_instruction;
                        rd_en_q <= 1'b1;
                        state_q <= ST_FETCH_OP;
                    end
                end
                ST_TRAP: ;
                default: begin
                    // Redirect wins over everything; an EMIT handshake in the same cycle
                    // has still been seen by the executor, so dropping valid is correct.
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        rd_en_q <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_FETCH_OP;
                    end else begin
                        case (state_q)
                            ST_FETCH_OP: begin
                                if (rd_done) begin
                                    opcode_q <= mem_rd_data;
                                    ins_pc_q <= pc_q;
                                    pc_q     <= pc_inc;
                                    imm0_q   <= '0;
                                    imm1_q   <= '0;
                                    cls_q    <= op_cls;
                                    rd_en_q  <= 1'b0;
                                    case (op_cls)
                                        IC_NONE: begin
                                            valid_q <= 1'b1;
                                            npc_q   <= pc_inc;
                                            state_q <= ST_EMIT;
                                        end
                                        IC_BAD: begin
                                            trap_q  <= 1'b1;
                                            tcode_q <= TRAP_UNKNOWN_OP;
                                            state_q <= ST_TRAP;
                                        end
                                        default: state_q <= ST_FETCH_IMM0;
                                    endcase
                                end else begin
                                    rd_en_q <= 1'b1;
                                end
                            end
                            ST_FETCH_IMM0, ST_FETCH_IMM1: begin
                                if (rd_done) begin
                                    pc_q    <= pc_inc;
                                    rd_en_q <= 1'b0;
                                    if ((state_q == ST_FETCH_IMM0) && (cls_q == IC_BLOCKTYPE)) begin
                                        imm0_q  <= {24'd0, mem_rd_data};
                                        valid_q <= 1'b1;
                                        npc_q   <= pc_inc;
                                        state_q <= ST_EMIT;
                                    end else if (leb_ovf) begin
                                        trap_q  <= 1'b1;
                                        tcode_q <= TRAP_LEB_OVERLONG;
                                        state_q <= ST_TRAP;
                                    end else if (leb_done) begin
                                        if (state_q == ST_FETCH_IMM0)
                                            imm0_q <= leb_value;
                                        else
                                            imm1_q <= leb_value;
                                        if ((state_q == ST_FETCH_IMM0) && (cls_q == IC_MEMARG)) begin
                                            state_q <= ST_FETCH_IMM1;
                                        end else begin
                                            valid_q <= 1'b1;
                                            npc_q   <= pc_inc;
                                            state_q <= ST_EMIT;
                                        end
                                    end
                                end else begin
                                    rd_en_q <= 1'b1;
                                end
                            end
                            ST_EMIT: begin
                                if (ins_ready) begin
                                    valid_q <= 1'b0;
                                    rd_en_q <= 1'b1;
                                    state_q <= ST_FETCH_OP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign mem_rd_en   = rd_en_q;
    assign ins_valid   = valid_q;
    assign ins_opcode  = opcode_q;
    assign ins_imm0    = imm0_q;
    assign ins_imm1    = imm1_q;
    assign ins_pc      = ins_pc_q;
    assign ins_next_pc = npc_q;
    assign trap        = trap_q;
    assign trap_code   = tcode_q;

endmodule

// File: tb/tb_wasm_fetch_decode.sv
// Self-checking bench for wasm_fetch_decode: random-latency byte memory, random bytecode
// program decoded by an arithmetic reference model, plus directed redirect/reset/trap scenarios.
module tb_wasm_fetch_decode;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rom_mapped = 1'b0;
    logic [AW-1:0] first_instruction = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rd_data = '0;
    logic          mem_rd_ready = 1'b0;
    logic          ins_valid;
    logic          ins_ready = 1'b0;
    logic [7:0]    ins_opcode;
    logic [31:0]   ins_imm0;
    logic [31:0]   ins_imm1;
    logic [AW-1:0] ins_pc;
    logic [AW-1:0] ins_next_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          trap;
    logic [1:0]    trap_code;

    logic [7:0]  mem [1024];
    int          errors = 0;
    int          checks = 0;
    int unsigned reads = 0;
    int unsigned lat = 0;
    int unsigned exp_pc = 0;

    wasm_fetch_decode #(.ADDR_W(AW), .MAX_LEB_BYTES(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rom_mapped        (rom_mapped),
        .first_instruction (first_instruction),
        .mem_addr          (mem_addr),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_ready      (mem_rd_ready),
        .ins_valid         (ins_valid),
        .ins_ready         (ins_ready),
        .ins_opcode        (ins_opcode),
        .ins_imm0          (ins_imm0),
        .ins_imm1          (ins_imm1),
        .ins_pc            (ins_pc),
        .ins_next_pc       (ins_next_pc),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .trap              (trap),
        .trap_code         (trap_code)
    );

    always #5 clk = ~clk;

    // Code memory: answers an observed request after 0..2 idle cycles with a one-cycle ready pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_rd_ready = 1'b0;
            lat = 0;
        end else if (mem_rd_ready) begin
            mem_rd_ready = 1'b0;
        end else if (mem_rd_en) begin
            if (lat == 0) begin
                mem_rd_data  = mem[mem_addr[9:0]];
                mem_rd_ready = 1'b1;
                reads++;
                lat = $urandom_range(0, 2);
            end else begin
                lat--;
            end
        end
    end

    // 0 none, 1 blocktype, 2 uleb, 3 sleb, 4 memarg, 5 unknown
    function automatic int cls_of(input logic [7:0] op);
        int c;
        c = 5;
        if (op == 8'h00 || op == 8'h01 || op == 8'h0B || op == 8'h0F || op == 8'h1A || op == 8'h1B) c = 0;
        else if (op >= 8'h45 && op <= 8'hC4) c = 0;
        else if (op >= 8'h02 && op <= 8'h04) c = 1;
        else if (op == 8'h0C || op == 8'h0D || op == 8'h10) c = 2;
        else if (op >= 8'h20 && op <= 8'h24) c = 2;
        else if (op == 8'h41) c = 3;
        else if (op >= 8'h28 && op <= 8'h3E) c = 4;
        return c;
    endfunction

    function automatic void read_leb(inout int unsigned p, input bit sgn,
                                     output logic [31:0] v, output bit bad);
        longint unsigned acc;
        logic [7:0] b;
        acc = 0;
        bad = 1'b1;
        v   = '0;
        for (int n = 0; n < 5; n++) begin
            b = mem[p[9:0]];
            p++;
            acc += 64'(b[6:0]) << (7 * n);
            if (!b[7]) begin
                if (sgn && b[6] && (7 * (n + 1) < 32)) acc -= 64'd1 << (7 * (n + 1));
                v   = acc[31:0];
                bad = 1'b0;
                return;
            end
        end
    endfunction

    function automatic void ref_decode(input int unsigned pc, output logic [7:0] op,
                                       output logic [31:0] i0, output logic [31:0] i1,
                                       output int unsigned npc, output int tc);
        int unsigned p;
        bit bad;
        bad = 1'b0;
        op  = mem[pc[9:0]];
        p   = pc + 1;
        i0  = '0;
        i1  = '0;
        tc  = 0;
        case (cls_of(op))
            1: begin i0 = {24'd0, mem[p[9:0]]}; p++; end
            2: read_leb(p, 1'b0, i0, bad);
            3: read_leb(p, 1'b1, i0, bad);
            4: begin
                read_leb(p, 1'b0, i0, bad);
                if (!bad) read_leb(p, 1'b0, i1, bad);
            end
            5: tc = 1;
            default: ;
        endcase
        if (bad) tc = 2;
        npc = p;
    endfunction

    task automatic emit_leb(inout int unsigned p);
        int unsigned k;
        logic [7:0] b;
        k = $urandom_range(1, 5);
        for (int unsigned j = 0; j < k; j++) begin
            b = 8'($urandom) & 8'h7F;
            if (j < k - 1) b = b | 8'h80;
            mem[p[9:0]] = b;
            p++;
        end
    endtask

    task automatic load_memory();
        int unsigned p;
        logic [7:0] op;
        logic [7:0] boot [17];
        boot = '{8'h41, 8'hE5, 8'h8E, 8'h26, 8'h41, 8'h7F, 8'h20, 8'h03, 8'h6A,
                 8'h28, 8'h02, 8'h80, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        for (int i = 0; i < 1024; i++) mem[i] = 8'h01;
        for (int i = 0; i < 17; i++) mem[32'h30 + i] = boot[i];
        mem[32'h80] = 8'h10; mem[32'h81] = 8'hFF; mem[32'h82] = 8'hFF; mem[32'h83] = 8'h01;
        mem[32'h90] = 8'h6A;
        mem[32'hA0] = 8'hFE;
        mem[32'hB0] = 8'h41;
        for (int i = 1; i <= 5; i++) mem[32'hB0 + i] = 8'hFF;
        p = 32'h100;
        for (int i = 0; i < 40; i++) begin
            do op = 8'($urandom); while (cls_of(op) == 5);
            mem[p[9:0]] = op;
            p++;
            case (cls_of(op))
                1: begin mem[p[9:0]] = 8'($urandom); p++; end
                2, 3: emit_leb(p);
                4: begin emit_leb(p); emit_leb(p); end
                default: ;
            endcase
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); #1;
            if (ins_valid === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ins_valid_timeout: ins_valid=0 after 300 cycles, required 1");
        end
    endtask

    task automatic accept(input bit redir, input logic [AW-1:0] rpc);
        ins_ready = 1'b1;
        redirect_valid = redir;
        redirect_pc = rpc;
        @(negedge clk); #1;
        ins_ready = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (mem_rd_en !== 1'b0 || ins_valid !== 1'b0 || trap !== 1'b0 || trap_code !== 2'd0 ||
            mem_addr !== '0 || ins_opcode !== '0 || ins_imm0 !== '0 || ins_imm1 !== '0 ||
            ins_pc !== '0 || ins_next_pc !== '0) begin
            errors++;
            $display("FAIL reset_values: rd_en=%b valid=%b trap=%b code=%0d addr=%0h op=%02h, required all 0",
                     mem_rd_en, ins_valid, trap, trap_code, mem_addr, ins_opcode);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk); #1;
            if (mem_rd_en !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL idle_no_read: mem_rd_en=1 while rom_mapped=0, required 0");
        end
    endtask

    task automatic test_boot();
        bit got;
        logic [7:0] eop; logic [31:0] e0, e1; int unsigned enpc; int tc;
        first_instruction = 32'h30;
        rom_mapped = 1'b1;
        exp_pc = 32'h30;
        wait_valid(got);
        rom_mapped = 1'b0;
        if (got) begin
            checks++;
            if (ins_opcode !== 8'h41 || ins_imm0 !== 32'd624485 || ins_imm1 !== 32'd0 ||
                ins_pc !== 32'h30 || ins_next_pc !== 32'h34) begin
                errors++;
                $display("FAIL boot_const: op=%02h imm0=%0d imm1=%0d pc=%0h npc=%0h, required 41 624485 0 30 34",
                         ins_opcode, ins_imm0, ins_imm1, ins_pc, ins_next_pc);
            end
            ref_decode(exp_pc, eop, e0, e1, enpc, tc);
            checks++;
            if (ins_imm0 !== e0 || ins_next_pc !== enpc) begin
                errors++;
                $display("FAIL boot_model: imm0=%08h npc=%0h, required %08h %0h", ins_imm0, ins_next_pc, e0, enpc);
            end
            exp_pc = enpc;
        end
        accept(1'b0, '0);
    endtask

    task automatic test_signed();
        bit got;
        logic [7:0] eop; logic [31:0] e0, e1; int unsigned enpc; int tc;
        logic [7:0]  lit_op [3];
        logic [31:0] lit_i0 [3];
        lit_op = '{8'h41, 8'h20, 8'h6A};
        lit_i0 = '{32'hFFFF_FFFF, 32'd3, 32'd0};
        for (int i = 0; i < 3; i++) begin
            wait_valid(got);
            if (got) begin
                ref_decode(exp_pc, eop, e0, e1, enpc, tc);
                checks++;
                if (ins_opcode !== eop || ins_imm0 !== e0 || ins_imm1 !== e1 ||
                    ins_pc !== exp_pc || ins_next_pc !== enpc || ins_opcode !== lit_op[i] ||
                    ins_imm0 !== lit_i0[i]) begin
                    errors++;
                    $display("FAIL signed_seq[%0d]: op=%02h imm0=%08h imm1=%08h pc=%0h npc=%0h, required %02h %08h %08h %0h %0h",
                             i, ins_opcode, ins_imm0, ins_imm1, ins_pc, ins_next_pc,
                             lit_op[i], lit_i0[i], e1, exp_pc, enpc);
                end
                exp_pc = enpc;
            end
            accept(1'b0, '0);
        end
    endtask

    task automatic test_memarg();
        bit got, bad;
        logic [7:0] op0; logic [31:0] a0, a1, p0, n0;
        wait_valid(got);
        if (got) begin
            checks++;
            if (ins_opcode !== 8'h28 || ins_imm0 !== 32'd2 || ins_imm1 !== 32'd128 ||
                ins_pc !== exp_pc || ins_next_pc !== exp_pc + 4) begin
                errors++;
                $display("FAIL memarg_value: op=%02h imm0=%0d imm1=%0d pc=%0h npc=%0h, required 28 2 128 %0h %0h",
                         ins_opcode, ins_imm0, ins_imm1, ins_pc, ins_next_pc, exp_pc, exp_pc + 4);
            end
            op0 = ins_opcode; a0 = ins_imm0; a1 = ins_imm1; p0 = ins_pc; n0 = ins_next_pc;
            bad = 1'b0;
            repeat (5) begin
                @(negedge clk); #1;
                if (ins_valid !== 1'b1 || mem_rd_en !== 1'b0 || ins_opcode !== op0 ||
                    ins_imm0 !== a0 || ins_imm1 !== a1 || ins_pc !== p0 || ins_next_pc !== n0)
                    bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL memarg_hold: valid=%b rd_en=%b op=%02h imm0=%0d, required stable 1 0 28 2",
                         ins_valid, mem_rd_en, ins_opcode, ins_imm0);
            end
        end
        accept(1'b1, 32'h100);
        exp_pc = 32'h100;
    endtask

    task automatic test_random();
        bit got;
        logic [7:0] eop; logic [31:0] e0, e1; int unsigned enpc; int tc;
        for (int i = 0; i < 40; i++) begin
            wait_valid(got);
            if (!got) break;
            ref_decode(exp_pc, eop, e0, e1, enpc, tc);
            checks++;
            if (ins_opcode !== eop || ins_imm0 !== e0 || ins_imm1 !== e1 ||
                ins_pc !== exp_pc || ins_next_pc !== enpc) begin
                errors++;
                $display("FAIL rand_ins[%0d]: op=%02h imm0=%08h imm1=%08h pc=%0h npc=%0h, required %02h %08h %08h %0h %0h",
                         i, ins_opcode, ins_imm0, ins_imm1, ins_pc, ins_next_pc, eop, e0, e1, exp_pc, enpc);
            end
            exp_pc = enpc;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
            accept(i == 39, 32'h80);
        end
    endtask

    task automatic test_redirect_mid_leb();
        bit found, got;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (mem_rd_ready && mem_addr == 32'h82) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_reach: no read of 0x82 within 200 cycles, required one");
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h90;
        @(negedge clk); #1;
        redirect_valid = 1'b0;
        wait_valid(got);
        if (got) begin
            checks++;
            if (ins_opcode !== 8'h6A || ins_pc !== 32'h90 || ins_next_pc !== 32'h91 ||
                ins_imm0 !== 32'd0 || ins_imm1 !== 32'd0) begin
                errors++;
                $display("FAIL redir_resume: op=%02h pc=%0h npc=%0h imm0=%0h, required 6A 90 91 0",
                         ins_opcode, ins_pc, ins_next_pc, ins_imm0);
            end
        end
        accept(1'b0, '0);
    endtask

    task automatic test_reset_midread();
        bit found, got;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (mem_rd_en && !mem_rd_ready) begin found = 1'b1; break; end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || mem_rd_en !== 1'b0 || ins_valid !== 1'b0 || mem_addr !== '0 || trap !== 1'b0) begin
            errors++;
            $display("FAIL reset_midread: found=%b rd_en=%b valid=%b addr=%0h trap=%b, required 1 0 0 0 0",
                     found, mem_rd_en, ins_valid, mem_addr, trap);
        end
        repeat (3) @(negedge clk);
        first_instruction = 32'h30;
        rom_mapped = 1'b1;
        rst_n = 1'b1;
        wait_valid(got);
        if (got) begin
            checks++;
            if (ins_opcode !== 8'h41 || ins_imm0 !== 32'd624485 || ins_pc !== 32'h30 || ins_next_pc !== 32'h34) begin
                errors++;
                $display("FAIL refetch: op=%02h imm0=%0d pc=%0h npc=%0h, required 41 624485 30 34",
                         ins_opcode, ins_imm0, ins_pc, ins_next_pc);
            end
        end
        accept(1'b0, '0);
    endtask

    task automatic test_trap(input logic [AW-1:0] entry, input int unsigned want_reads);
        bit got, bad;
        int unsigned r0;
        logic [7:0] eop; logic [31:0] e0, e1; int unsigned enpc; int tc;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ref_decode(entry, eop, e0, e1, enpc, tc);
        first_instruction = entry;
        rom_mapped = 1'b1;
        r0 = reads;
        rst_n = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (trap === 1'b1) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || trap_code !== 2'(tc) || ins_valid !== 1'b0 || mem_rd_en !== 1'b0 ||
            reads - r0 != want_reads) begin
            errors++;
            $display("FAIL trap_%0h: trap=%b code=%0d valid=%b rd_en=%b reads=%0d, required 1 %0d 0 0 %0d",
                     entry, trap, trap_code, ins_valid, mem_rd_en, reads - r0, tc, want_reads);
        end
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
            if (mem_rd_en !== 1'b0 || trap !== 1'b1 || trap_code !== 2'(tc) || ins_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL trap_sticky_%0h: trap=%b code=%0d rd_en=%b, required 1 %0d 0",
                     entry, trap, trap_code, mem_rd_en, tc);
        end
    endtask

    initial begin
        load_memory();
        test_reset();
        test_boot();
        test_signed();
        test_memarg();
        test_random();
        test_redirect_mid_leb();
        test_reset_midread();
        test_trap(32'hA0, 1);
        test_trap(32'hB0, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
